cam_capture: RTL and testbench
==============================

# cam_capture

Parametrised camera pixel-capture block for the OV7670-class parallel camera path. It generates the camera master clock and synchronises the camera's p_clock, vsync, href and p_data into the system clock domain. It then assembles 1- or 2-byte pixels, tracks row/column, and emits one-cycle pixel strobes plus frame-done pulses. It sits between the camera pins and the pixel consumer (VGA pass-through or frame buffer), replacing the fixed 16-bit reader.

## Interface
Parameters:
- BYTES_PER_PIXEL, 2: bytes per pixel; legal values 1 or 2.
- COL_W, 10: width of col counter.
- ROW_W, 10: width of row counter.
- MAX_COLS, 640: pixels accepted per line; extras dropped.
- XCLK_DIV, 1: x_clock half-period in clk cycles; legal range ≥1.

Ports:
- clk  in  1  system clock; must be ≥4× p_clock frequency.
- resetn  in  1  asynchronous, active-low reset.
- vsync  in  1  camera vsync, asynchronous; high means vertical blank.
- href  in  1  camera href, asynchronous; high means active line.
- p_clock  in  1  camera pixel clock, asynchronous.
- p_data  in  8  camera data, valid at p_clock rising edge.
- x_clock  out  1  camera master clock, clk/(2·XCLK_DIV).
- pixel_valid  out  1  one-cycle strobe: pixel_data/row/col valid.
- pixel_data  out  8·BYTES_PER_PIXEL  assembled pixel; first byte in MSBs.
- row  out  ROW_W  row of current pixel.
- col  out  COL_W  column of current pixel.
- frame_done  out  1  one-cycle pulse at end of frame.
- line_overflow  out  1  one-cycle pulse when a byte is dropped because col ≥ MAX_COLS.

## Operation
- Synchronisers: vsync, href, p_clock and p_data each pass through a 2-flop chain; a third p_clock stage forms the rising-edge detect `pe`. The byte used is the stage-2 p_data, aligned with the stage-2 p_clock.
- FSM states:
  - SYNC, the reset state: wait for synced vsync=1, then go to VBLANK. This discards the partial frame after reset.
  - VBLANK: on vsync 1→0, clear row to 0 and go to ACTIVE.
  - ACTIVE: capture bytes; on vsync 0→1, pulse frame_done and go to VBLANK.
- Capture happens only in ACTIVE with href=1 and pe=1.
  - A byte phase counter (0..BYTES_PER_PIXEL-1) shifts the byte in MSB-first.
  - When the final byte arrives and col < MAX_COLS, pixel_valid pulses and pixel_data, row and col update together.
  - col then increments after the strobe, i.e. the strobe carries the pre-increment col.
- Dropped pixels: when col = MAX_COLS, the byte is dropped, line_overflow pulses and col holds.
- href 1→0 in ACTIVE:
  - byte phase and col clear;
  - row increments if at least one pixel was emitted on that line;
  - a dangling partial pixel is discarded with no strobe.
- row wraps modulo 2^ROW_W.
- vsync rising mid-line ends the frame; phase and col clear.
- x_clock: a counter toggles x_clock every XCLK_DIV clk cycles. It runs in every state, including SYNC.

## Timing
- Reset values: x_clock, pixel_valid, frame_done and line_overflow = 0; pixel_data, row and col = 0; FSM = SYNC.
- Latency: pixel_valid asserts 3 clk cycles after the first clk edge that samples the final byte's p_clock high.
- frame_done asserts 3 clk cycles after vsync is first sampled high.
- pixel_valid and frame_done never coincide. If a final byte and a vsync rise fall on the same cycle, the pixel strobe is issued first and frame_done follows one cycle later.
- Outputs are registered; pixel_data holds between strobes.

## Configuration
- CAM_CAPTURE_WINDOW_EN defined:
  - Adds inputs win_x0 and win_w (COL_W) and win_y0 and win_h (ROW_W), sampled at every vsync 1→0.
  - pixel_valid fires only for win_x0 ≤ col < win_x0+win_w and win_y0 ≤ row < win_y0+win_h.
  - row/col stay absolute sensor coordinates.
  - frame_done is unaffected.
- Not defined: no window ports; every accepted pixel is strobed.

## Structure
- Package cam_pkg holds:
  - FSM state enum (SYNC, VBLANK, ACTIVE);
  - default geometry constants (640×480, RGB565 = 2 bytes).
- One sub-module, cam_sync: 2-flop synchroniser plus edge detector, instanced for p_clock, vsync and href.

## Test plan
- Reset mid-line, then one frame of 4 lines × 3 pixels, BPP=2, bytes 0x12,0x34… → no strobes before the first vsync pulse; 12 strobes, first pixel_data=0x1234 at row 0/col 0, last at row 3/col 2; one frame_done.
- BPP=1, one line of 5 bytes 0xA0..0xA4 → 5 strobes, col 0..4, pixel_data equals each byte.
- MAX_COLS=4, line of 6 pixels → 4 strobes, 2 line_overflow pulses, col holds at 4; next line restarts at col 0, row+1.
- BPP=2, href drops after 3 bytes → 1 strobe; odd byte discarded; next line first pixel correct.
- vsync rises one pclk after last byte → pixel strobe, then frame_done on the following cycle.
- With CAM_CAPTURE_WINDOW_EN, window x0=1,w=2,y0=1,h=1 on a 4×3 frame → exactly 2 strobes at (row 1, col 1) and (row 1, col 2).

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera capture path.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2
    } cam_state_e;

    localparam int DEF_COLS = 640;
    localparam int DEF_ROWS = 480;
    localparam int DEF_BPP  = 2;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchroniser with a third stage for registered rise/fall pulses;
// level is the third stage so it lines up with the edge pulses.
module cam_sync (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_r, s2_r, s3_r, rise_r, fall_r;

    // Synchroniser chain and edge pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            s3_r   <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            s1_r   <= async_in;
            s2_r   <= s1_r;
            s3_r   <= s2_r;
            rise_r <= s2_r & ~s3_r;
            fall_r <= ~s2_r & s3_r;
        end
    end

    assign level = s3_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/cam_capture.sv
// Camera pixel capture: syncs the parallel camera bus, assembles pixels, tracks row/col.
// Optional capture window enabled by defining CAM_CAPTURE_WINDOW_EN.
module cam_capture import cam_pkg::*; #(
    parameter int BYTES_PER_PIXEL = DEF_BPP,
    parameter int COL_W           = 10,
    parameter int ROW_W           = 10,
    parameter int MAX_COLS        = DEF_COLS,
    parameter int XCLK_DIV        = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         vsync,
    input  logic                         href,
    input  logic                         p_clock,
    input  logic [7:0]                   p_data,
`ifdef CAM_CAPTURE_WINDOW_EN
    input  logic [COL_W-1:0]             win_x0,
    input  logic [COL_W-1:0]             win_w,
    input  logic [ROW_W-1:0]             win_y0,
    input  logic [ROW_W-1:0]             win_h,
`endif
    output logic                         x_clock,
    output logic                         pixel_valid,
    output logic [8*BYTES_PER_PIXEL-1:0] pixel_data,
    output logic [ROW_W-1:0]             row,
    output logic [COL_W-1:0]             col,
    output logic                         frame_done,
    output logic                         line_overflow
);

    localparam int PIX_W = 8 * BYTES_PER_PIXEL;

    logic vs_lvl_s, vs_rise_s, vs_fall_s;
    logic href_lvl_s, href_rise_s, href_fall_s;
    logic pclk_lvl_s, pclk_rise_s, pclk_fall_s;
    logic sync_unused_s;

    cam_sync u_sync_pclk (.clk(clk), .resetn(resetn), .async_in(p_clock),
                          .level(pclk_lvl_s), .rise(pclk_rise_s), .fall(pclk_fall_s));
    cam_sync u_sync_vs   (.clk(clk), .resetn(resetn), .async_in(vsync),
                          .level(vs_lvl_s), .rise(vs_rise_s), .fall(vs_fall_s));
    cam_sync u_sync_href (.clk(clk), .resetn(resetn), .async_in(href),
                          .level(href_lvl_s), .rise(href_rise_s), .fall(href_fall_s));

    assign sync_unused_s = href_rise_s ^ pclk_lvl_s ^ pclk_fall_s;

    logic [7:0]       data1_r, data2_r, data3_r;
    logic [15:0]      xdiv_r;
    logic             xclk_r;
    cam_state_e       state_r, state_s;
    logic [ROW_W-1:0] row_r, row_s;
    logic [COL_W-1:0] col_r, col_s;
    logic [PIX_W-1:0] pix_r, pix_s;
    logic [7:0]       byte0_r, byte0_s;
    logic             phase_r, phase_s;
    logic             line_pix_r, line_pix_s;
    logic             inc_pend_r, inc_pend_s;
    logic             fd_pend_r, fd_pend_s;
    logic             pv_r, pv_s, fd_r, fd_s, ovf_r, ovf_s;
    logic             capture_s, last_byte_s, win_hit_s;
    logic [7:0]       byte_s;

    // Data pipeline: two sync stages plus one to align with the registered pclk edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data1_r <= 8'h00;
            data2_r <= 8'h00;
            data3_r <= 8'h00;
        end else begin
            data1_r <= p_data;
            data2_r <= data1_r;
            data3_r <= data2_r;
        end
    end

    assign byte_s = data3_r;

    // Camera master clock divider, free-running in every state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xdiv_r <= 16'd0;
            xclk_r <= 1'b0;
        end else if (xdiv_r == 16'(XCLK_DIV - 1)) begin
            xdiv_r <= 16'd0;
            xclk_r <= ~xclk_r;
        end else begin
            xdiv_r <= xdiv_r + 16'd1;
        end
    end

`ifdef CAM_CAPTURE_WINDOW_EN
    logic [COL_W-1:0] wx0_r, ww_r;
    logic [ROW_W-1:0] wy0_r, wh_r;

    // Window bounds are latched at the start of each frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wx0_r <= {COL_W{1'b0}};
            ww_r  <= {COL_W{1'b0}};
            wy0_r <= {ROW_W{1'b0}};
            wh_r  <= {ROW_W{1'b0}};
        end else if (vs_fall_s) begin
            wx0_r <= win_x0;
            ww_r  <= win_w;
            wy0_r <= win_y0;
            wh_r  <= win_h;
        end
    end

    assign win_hit_s = (col_r >= wx0_r) && ({1'b0, col_r} < ({1'b0, wx0_r} + {1'b0, ww_r})) &&
                       (row_r >= wy0_r) && ({1'b0, row_r} < ({1'b0, wy0_r} + {1'b0, wh_r}));
`else
    assign win_hit_s = 1'b1;
`endif

    // FSM state and capture datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_SYNC;
            row_r      <= {ROW_W{1'b0}};
            col_r      <= {COL_W{1'b0}};
            pix_r      <= {PIX_W{1'b0}};
            byte0_r    <= 8'h00;
            phase_r    <= 1'b0;
            line_pix_r <= 1'b0;
            inc_pend_r <= 1'b0;
            fd_pend_r  <= 1'b0;
            pv_r       <= 1'b0;
            fd_r       <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            row_r      <= row_s;
            col_r      <= col_s;
            pix_r      <= pix_s;
            byte0_r    <= byte0_s;
            phase_r    <= phase_s;
            line_pix_r <= line_pix_s;
            inc_pend_r <= inc_pend_s;
            fd_pend_r  <= fd_pend_s;
            pv_r       <= pv_s;
            fd_r       <= fd_s;
            ovf_r      <= ovf_s;
        end
    end

    // Next-state and capture logic; col increments the cycle after its strobe.
    always_comb begin
        state_s     = state_r;
        row_s       = row_r;
        col_s       = inc_pend_r ? (col_r + {{(COL_W-1){1'b0}}, 1'b1}) : col_r;
        pix_s       = pix_r;
        byte0_s     = byte0_r;
        phase_s     = phase_r;
        line_pix_s  = line_pix_r;
        inc_pend_s  = 1'b0;
        fd_pend_s   = 1'b0;
        pv_s        = 1'b0;
        ovf_s       = 1'b0;
        fd_s        = fd_pend_r;
        capture_s   = (state_r == ST_ACTIVE) && href_lvl_s && pclk_rise_s;
        last_byte_s = (BYTES_PER_PIXEL == 1) || phase_r;

        case (state_r)
            ST_SYNC: begin
                if (vs_lvl_s) begin
                    state_s = ST_VBLANK;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_VBLANK: begin
                if (vs_fall_s) begin
                    state_s    = ST_ACTIVE;
                    row_s      = {ROW_W{1'b0}};
                    col_s      = {COL_W{1'b0}};
                    phase_s    = 1'b0;
                    line_pix_s = 1'b0;
                end else begin
                    state_s = ST_VBLANK;
                end
            end
            ST_ACTIVE: begin
                if (capture_s) begin
                    if (col_r >= COL_W'(MAX_COLS)) begin
                        ovf_s   = 1'b1;
                        phase_s = 1'b0;
                    end else if (last_byte_s) begin
                        pv_s       = win_hit_s;
                        pix_s      = win_hit_s ? PIX_W'({byte0_r, byte_s}) : pix_r;
                        inc_pend_s = 1'b1;
                        line_pix_s = 1'b1;
                        phase_s    = 1'b0;
                    end else begin
                        byte0_s = byte_s;
                        phase_s = 1'b1;
                    end
                end else if (href_fall_s) begin
                    phase_s    = 1'b0;
                    col_s      = {COL_W{1'b0}};
                    row_s      = row_r + ROW_W'(line_pix_r);
                    line_pix_s = 1'b0;
                end else begin
                    phase_s = phase_r;
                end

                // A pixel strobe on the same cycle as vsync rise pushes frame_done back a cycle.
                if (vs_rise_s) begin
                    state_s    = ST_VBLANK;
                    phase_s    = 1'b0;
                    col_s      = {COL_W{1'b0}};
                    inc_pend_s = 1'b0;
                    line_pix_s = 1'b0;
                    if (pv_s) begin
                        fd_pend_s = 1'b1;
                    end else begin
                        fd_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s = ST_SYNC;
            end
        endcase
    end

    assign x_clock       = xclk_r;
    assign pixel_valid   = pv_r;
    assign pixel_data    = pix_r;
    assign row           = row_r;
    assign col           = col_r;
    assign frame_done    = fd_r;
    assign line_overflow = ovf_r;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: three instances (BPP=2; BPP=1 with 4 columns; BPP=1 with slow x_clock)
// share one camera bus; strobes are logged and compared against expected tables.
module tb_cam_capture;

    logic       clk = 1'b0;
    logic       resetn, vsync, href, p_clock;
    logic [7:0] p_data;

    always #5 clk = ~clk;

`ifdef CAM_CAPTURE_WINDOW_EN
    logic [9:0] win_x0, win_w, win_y0, win_h;
`endif

    logic        pv_a, fd_a, ovf_a, xc_a;
    logic [15:0] pd_a;
    logic [9:0]  row_a, col_a;
    logic        pv_b, fd_b, ovf_b, xc_b;
    logic [7:0]  pd_b;
    logic [9:0]  row_b, col_b;
    logic        pv_c, fd_c, ovf_c, xc_c;
    logic [7:0]  pd_c;
    logic [9:0]  row_c, col_c;

    cam_capture #(.BYTES_PER_PIXEL(2), .COL_W(10), .ROW_W(10), .MAX_COLS(640), .XCLK_DIV(1)) dut_a (
        .clk(clk), .resetn(resetn), .vsync(vsync), .href(href), .p_clock(p_clock), .p_data(p_data),
`ifdef CAM_CAPTURE_WINDOW_EN
        .win_x0(win_x0), .win_w(win_w), .win_y0(win_y0), .win_h(win_h),
`endif
        .x_clock(xc_a), .pixel_valid(pv_a), .pixel_data(pd_a), .row(row_a), .col(col_a),
        .frame_done(fd_a), .line_overflow(ovf_a));

    cam_capture #(.BYTES_PER_PIXEL(1), .COL_W(10), .ROW_W(10), .MAX_COLS(4), .XCLK_DIV(1)) dut_b (
        .clk(clk), .resetn(resetn), .vsync(vsync), .href(href), .p_clock(p_clock), .p_data(p_data),
`ifdef CAM_CAPTURE_WINDOW_EN
        .win_x0(win_x0), .win_w(win_w), .win_y0(win_y0), .win_h(win_h),
`endif
        .x_clock(xc_b), .pixel_valid(pv_b), .pixel_data(pd_b), .row(row_b), .col(col_b),
        .frame_done(fd_b), .line_overflow(ovf_b));

    cam_capture #(.BYTES_PER_PIXEL(1), .COL_W(10), .ROW_W(10), .MAX_COLS(640), .XCLK_DIV(3)) dut_c (
        .clk(clk), .resetn(resetn), .vsync(vsync), .href(href), .p_clock(p_clock), .p_data(p_data),
`ifdef CAM_CAPTURE_WINDOW_EN
        .win_x0(win_x0), .win_w(win_w), .win_y0(win_y0), .win_h(win_h),
`endif
        .x_clock(xc_c), .pixel_valid(pv_c), .pixel_data(pd_c), .row(row_c), .col(col_c),
        .frame_done(fd_c), .line_overflow(ovf_c));

    typedef struct {
        logic [9:0]  row;
        logic [9:0]  col;
        logic [15:0] data;
        int          cyc;
    } pix_t;

    typedef struct {
        int          dut;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [15:0] data;
    } vec_t;

    pix_t qa[$], qb[$], qc[$], exp_q[$];
    int   cyc = 0;
    int   fd_n [3] = '{0, 0, 0};
    int   fd_cyc [3] = '{0, 0, 0};
    int   ovf_n [3] = '{0, 0, 0};
    int   xt_a = 0, xt_c = 0, coinc = 0;
    logic xa_prev = 1'b0, xc_prev = 1'b0;
    int   checks = 0, errors = 0;
    int   fe_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (pv_a) qa.push_back('{row_a, col_a, pd_a, cyc});
        if (pv_b) qb.push_back('{row_b, col_b, {8'h00, pd_b}, cyc});
        if (pv_c) qc.push_back('{row_c, col_c, {8'h00, pd_c}, cyc});
        if (fd_a) begin fd_n[0] <= fd_n[0] + 1; fd_cyc[0] <= cyc; end
        if (fd_b) begin fd_n[1] <= fd_n[1] + 1; fd_cyc[1] <= cyc; end
        if (fd_c) begin fd_n[2] <= fd_n[2] + 1; fd_cyc[2] <= cyc; end
        if (ovf_a) ovf_n[0] <= ovf_n[0] + 1;
        if (ovf_b) ovf_n[1] <= ovf_n[1] + 1;
        if (ovf_c) ovf_n[2] <= ovf_n[2] + 1;
        if ((pv_a && fd_a) || (pv_b && fd_b) || (pv_c && fd_c)) coinc <= coinc + 1;
        if (xc_a != xa_prev) xt_a <= xt_a + 1;
        if (xc_c != xc_prev) xt_c <= xt_c + 1;
        xa_prev <= xc_a;
        xc_prev <= xc_c;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic pix_t get_ent(input int d, input int i);
        case (d)
            0:       return qa[i];
            1:       return qb[i];
            default: return qc[i];
        endcase
    endfunction

    function automatic void add(input int r, input int c, input logic [15:0] d);
        exp_q.push_back('{10'(r), 10'(c), d, 0});
    endfunction

    task automatic chk_strobes(input string nm, input int d, input int base);
        int n;
        n = qsize(d) - base;
        check({nm, " count"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            pix_t g;
            g = get_ent(d, base + i);
            check($sformatf("%s px%0d", nm, i), {28'h0, g.row, g.col, g.data},
                  {28'h0, exp_q[i].row, exp_q[i].col, exp_q[i].data});
        end
    endtask

    function automatic logic [7:0] s1b(input int k);
        return 8'(32'h12 + 32'h22 * k);
    endfunction

    task automatic pbyte(input logic [7:0] d);
        p_clock = 1'b0;
        p_data  = d;
        #40;
        p_clock = 1'b1;
        #40;
    endtask

    task automatic line_bytes(input int n, input logic [7:0] first, input logic [7:0] step);
        href = 1'b1;
        for (int k = 0; k < n; k++) pbyte(8'(first + step * 8'(k)));
    endtask

    task automatic line_end();
        p_clock = 1'b0;
        #40;
        href = 1'b0;
        #200;
    endtask

    task automatic frame_start();
        vsync = 1'b0;
        #300;
    endtask

    task automatic frame_end();
        @(posedge clk);
        #1;
        fe_cyc = cyc;
        vsync  = 1'b1;
        #300;
    endtask

    vec_t s2_tab [16] = '{
        '{0, 10'd0, 10'd0, 16'hA0A1}, '{0, 10'd0, 10'd1, 16'hA2A3}, '{0, 10'd1, 10'd0, 16'hB0B1},
        '{1, 10'd0, 10'd0, 16'h00A0}, '{1, 10'd0, 10'd1, 16'h00A1}, '{1, 10'd0, 10'd2, 16'h00A2},
        '{1, 10'd0, 10'd3, 16'h00A3}, '{1, 10'd1, 10'd0, 16'h00B0}, '{1, 10'd1, 10'd1, 16'h00B1},
        '{2, 10'd0, 10'd0, 16'h00A0}, '{2, 10'd0, 10'd1, 16'h00A1}, '{2, 10'd0, 10'd2, 16'h00A2},
        '{2, 10'd0, 10'd3, 16'h00A3}, '{2, 10'd0, 10'd4, 16'h00A4}, '{2, 10'd1, 10'd0, 16'h00B0},
        '{2, 10'd1, 10'd1, 16'h00B1}
    };

    initial begin
        int ba, bb, bc, f0, f1, f2, o1, t0a, t0c, c0;
        resetn  = 1'b0;
        vsync   = 1'b0;
        href    = 1'b1;
        p_clock = 1'b0;
        p_data  = 8'h00;
`ifdef CAM_CAPTURE_WINDOW_EN
        win_x0 = 10'd0; win_w = 10'd1023; win_y0 = 10'd0; win_h = 10'd1023;
`endif
        #2;
        // Reset asserted in the middle of a line.
        pbyte(8'h55);
        pbyte(8'h66);
        @(negedge clk); #1;
        check("rst outputs", {58'h0, pv_a, fd_a, ovf_a, xc_a, pd_a, row_a, col_a},
              {58'h0, 4'h0, 16'h0000, 10'd0, 10'd0});
        #3;
        resetn = 1'b1;
        pbyte(8'h77);
        pbyte(8'h88);
        pbyte(8'h99);
        line_end();
        check("no strobe pre-vsync", 64'(qa.size() + qb.size() + qc.size()), 64'd0);

        @(negedge clk); #1;
        t0a = xt_a; t0c = xt_c;
        repeat (60) @(negedge clk);
        #1;
        check("xclk div1 toggles", 64'(xt_a - t0a), 64'd60);
        #4;
        check("xclk div3 toggles", 64'(xt_c - t0c), 64'd20);

        // Frame 1: 4 lines x 3 pixels (BPP=2), 6 bytes per line.
        vsync = 1'b1;
        #300;
        ba = qa.size(); bb = qb.size(); bc = qc.size();
        f0 = fd_n[0]; o1 = ovf_n[1];
        frame_start();
        for (int i = 0; i < 4; i++) begin
            line_bytes(6, s1b(6 * i), 8'h22);
            if (i == 0) begin
                #100;
                check("s1 col a after line", 64'(col_a), 64'd3);
                check("s1 col b holds", 64'(col_b), 64'd4);
            end
            line_end();
            if (i == 0) check("s1 row a next line", 64'(row_a), 64'd1);
        end
        frame_end();
        check("s1 frame_done count", 64'(fd_n[0] - f0), 64'd1);
        check("s1 frame_done latency", 64'(fd_cyc[0] - fe_cyc), 64'd4);
        check("s1 overflow b", 64'(ovf_n[1] - o1), 64'd8);
        check("s1 strobes c", 64'(qc.size() - bc), 64'd24);
        exp_q.delete();
        for (int i = 0; i < 4; i++)
            for (int p = 0; p < 3; p++)
                add(i, p, {s1b(6 * i + 2 * p), s1b(6 * i + 2 * p + 1)});
        chk_strobes("s1 a", 0, ba);
        exp_q.delete();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                add(i, j, {8'h00, s1b(6 * i + j)});
        chk_strobes("s1 b", 1, bb);

        // Frame 2: odd-length line then a short line.
        ba = qa.size(); bb = qb.size(); bc = qc.size();
        f0 = fd_n[0]; o1 = ovf_n[1];
        frame_start();
        line_bytes(5, 8'hA0, 8'h01);
        line_end();
        line_bytes(2, 8'hB0, 8'h01);
        line_end();
        frame_end();
        check("s2 frame_done count", 64'(fd_n[0] - f0), 64'd1);
        check("s2 overflow b", 64'(ovf_n[1] - o1), 64'd1);
        for (int d = 0; d < 3; d++) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++)
                if (s2_tab[i].dut == d) add(int'(s2_tab[i].row), int'(s2_tab[i].col), s2_tab[i].data);
            chk_strobes($sformatf("s2 dut%0d", d), d, (d == 0) ? ba : ((d == 1) ? bb : bc));
        end

        // Frame 3: vsync rises on the same p_clock edge as the final byte.
        ba = qa.size(); bc = qc.size();
        f0 = fd_n[0]; f2 = fd_n[2];
        frame_start();
        line_bytes(1, 8'hC0, 8'h01);
        p_clock = 1'b0;
        p_data  = 8'hC1;
        #40;
        @(posedge clk);
        #1;
        c0      = cyc;
        vsync   = 1'b1;
        p_clock = 1'b1;
        #400;
        p_clock = 1'b0;
        href    = 1'b0;
        #300;
        exp_q.delete();
        add(0, 0, 16'hC0C1);
        chk_strobes("s3 a", 0, ba);
        if (qa.size() > ba) check("s3 pixel latency", 64'(qa[ba].cyc - c0), 64'd4);
        check("s3 fd count a", 64'(fd_n[0] - f0), 64'd1);
        check("s3 fd after pixel a", 64'(fd_cyc[0] - c0), 64'd5);
        check("s3 fd count c", 64'(fd_n[2] - f2), 64'd1);
        check("s3 fd after pixel c", 64'(fd_cyc[2] - c0), 64'd5);
        check("s3 strobes c", 64'(qc.size() - bc), 64'd2);

`ifdef CAM_CAPTURE_WINDOW_EN
        // Window x0=1 w=2 y0=1 h=1 over a 4x3 frame.
        win_x0 = 10'd1; win_w = 10'd2; win_y0 = 10'd1; win_h = 10'd1;
        ba = qa.size();
        f0 = fd_n[0];
        frame_start();
        for (int i = 0; i < 3; i++) begin
            line_bytes(8, 8'(8'h40 + 8'h10 * 8'(i)), 8'h01);
            line_end();
        end
        frame_end();
        exp_q.delete();
        add(1, 1, 16'h5253);
        add(1, 2, 16'h5455);
        chk_strobes("win a", 0, ba);
        check("win frame_done", 64'(fd_n[0] - f0), 64'd1);
`endif

        check("strobe/frame_done overlap", 64'(coinc), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
